// File: rtl/hilo_muldiv_ctrl_if.sv
// E-stage request/response bundle for the HI/LO multiply/divide controller.
interface hilo_muldiv_ctrl_if;
  logic        startE;
  logic [2:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        flushE;
  logic        stallE;
  logic        doneE;
  logic [63:0] hiloE;

  modport master (
    output startE, opE, srcaE, srcbE, flushE,
    input  stallE, doneE, hiloE
  );

  modport slave (
    input  startE, opE, srcaE, srcbE, flushE,
    output stallE, doneE, hiloE
  );
endinterface

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: registered single-cycle multiply, 32-step shift-subtract divide,
// MTHI/MTLO writes, and a stall request while a mult/div is in flight.
module hilo_muldiv_ctrl (
  input  logic              clk,
  input  logic              rst,
  hilo_muldiv_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e      state_q, state_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] res_q, res_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        msgn_q, msgn_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        nowr_q, nowr_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        accept;
  logic        md_op;
  logic        is_signed;
  logic [31:0] a_abs, b_abs;
  logic [63:0] mul_a64, mul_b64, prod;
  logic [32:0] rem_sh, rem_sub;
  logic        ge;
  logic [31:0] rem_nx, quo_nx;

  assign accept    = (state_q == IDLE) & bus.startE & ~bus.flushE;
  assign md_op     = ~bus.opE[2];
  assign is_signed = ~bus.opE[0];

  assign a_abs = (is_signed & bus.srcaE[31]) ? -bus.srcaE : bus.srcaE;
  assign b_abs = (is_signed & bus.srcbE[31]) ? -bus.srcbE : bus.srcbE;

  assign mul_a64 = {{32{msgn_q & opa_q[31]}}, opa_q};
  assign mul_b64 = {{32{msgn_q & opb_q[31]}}, opb_q};
  assign prod    = mul_a64 * mul_b64;

  // 33-bit compare: the shifted partial remainder can exceed 32 bits
  assign rem_sh  = {rem_q, quo_q[31]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign ge      = (rem_sh >= {1'b0, dvs_q});
  assign rem_nx  = ge ? rem_sub[31:0] : rem_sh[31:0];
  assign quo_nx  = {quo_q[30:0], ge};

  always_comb begin
    state_d = state_q;
    hilo_d  = hilo_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    msgn_d  = msgn_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    nowr_d  = nowr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.opE)
            OP_MTHI: hilo_d[63:32] = bus.srcaE;
            OP_MTLO: hilo_d[31:0]  = bus.srcaE;
            OP_MULT, OP_MULTU: begin
              opa_d   = bus.srcaE;
              opb_d   = bus.srcbE;
              msgn_d  = is_signed;
              nowr_d  = 1'b0;
              state_d = MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.srcbE == '0) begin
                nowr_d  = 1'b1;
                state_d = DONE;
              end else begin
                quo_d   = a_abs;
                rem_d   = '0;
                dvs_d   = b_abs;
                qneg_d  = is_signed & (bus.srcaE[31] ^ bus.srcbE[31]);
                rneg_d  = is_signed & bus.srcaE[31];
                nowr_d  = 1'b0;
                cnt_d   = '1;
                state_d = DIV;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        res_d   = prod;
        state_d = DONE;
      end
      DIV: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        if (cnt_q == '0) begin
          res_d   = {rneg_q ? -rem_nx : rem_nx, qneg_q ? -quo_nx : quo_nx};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: begin
        if (!nowr_q) hilo_d = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.flushE) begin
      state_d = IDLE;
      hilo_d  = hilo_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hilo_q  <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      msgn_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      nowr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
      res_q   <= res_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      msgn_q  <= msgn_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      nowr_q  <= nowr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stallE = (accept & md_op) | (state_q == MUL) | (state_q == DIV);
  assign bus.doneE  = (state_q == DONE);
  assign bus.hiloE  = hilo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: MT writes, mult/div results and latency,
// divide-by-zero, flush and reset mid-divide.
module tb_hilo_muldiv_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   done_seen;

  hilo_muldiv_ctrl_if bus();

  hilo_muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.doneE === 1'b1) done_seen++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic start, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.startE = start;
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
  endtask

  // Issue a mult/div at cycle T, count stall cycles up to DONE, then check HILO at DONE+1.
  task automatic do_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_stall, input logic [63:0] exp_hilo);
    int  n;
    bit  got_done;
    n = 0;
    got_done = 0;
    step(1'b1, op, a, b);
    for (int i = 0; i < 100 && !got_done; i++) begin
      #1;
      if (bus.doneE === 1'b1) begin
        got_done = 1;
        chk({tag, " stall@done"}, {63'd0, bus.stallE}, 64'd0);
      end else begin
        if (bus.stallE === 1'b1) n++;
        @(posedge clk); #1;
        bus.startE = 1'b0;
      end
    end
    chk({tag, " done"}, {63'd0, got_done}, 64'd1);
    chk({tag, " stalls"}, 64'(n), 64'(exp_stall));
    step(1'b0, 3'b000, '0, '0);
    #1;
    chk({tag, " hilo"}, bus.hiloE, exp_hilo);
    chk({tag, " done clr"}, {63'd0, bus.doneE}, 64'd0);
  endtask

  initial begin
    int d0;
    tests = 0;
    fails = 0;
    done_seen = 0;
    rst = 1'b1;
    bus.startE = 1'b0;
    bus.opE    = 3'b000;
    bus.srcaE  = '0;
    bus.srcbE  = '0;
    bus.flushE = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset hilo", bus.hiloE, 64'd0);
    chk("reset stall", {63'd0, bus.stallE}, 64'd0);
    chk("reset done", {63'd0, bus.doneE}, 64'd0);

    step(1'b1, 3'b100, 32'h12345678, '0);
    #1 chk("mthi stall", {63'd0, bus.stallE}, 64'd0);
    step(1'b1, 3'b101, 32'h9ABCDEF0, '0);
    #1 chk("mtlo stall", {63'd0, bus.stallE}, 64'd0);
    chk("mthi visible", bus.hiloE, 64'h12345678_00000000);
    step(1'b0, 3'b000, '0, '0);
    #1 chk("mt hilo", bus.hiloE, 64'h12345678_9ABCDEF0);

    do_md("mult -2*3",   3'b000, 32'hFFFFFFFE, 32'd3, 2, 64'hFFFFFFFF_FFFFFFFA);
    do_md("multu -2*3",  3'b001, 32'hFFFFFFFE, 32'd3, 2, 64'h00000002_FFFFFFFA);
    do_md("mult min*min", 3'b000, 32'h80000000, 32'h80000000, 2, 64'h40000000_00000000);
    do_md("multu max*max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 64'hFFFFFFFE_00000001);

    do_md("div -7/2",    3'b010, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);
    do_md("divu 100/7",  3'b011, 32'd100, 32'd7, 33, 64'h00000002_0000000E);
    do_md("div 7/-2",    3'b010, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);
    do_md("div min/-1",  3'b010, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);

    step(1'b1, 3'b100, 32'hAAAAAAAA, '0);
    step(1'b1, 3'b101, 32'h55555555, '0);
    do_md("divu by 0",   3'b011, 32'd1234, 32'd0, 1, 64'hAAAAAAAA_55555555);

    // Flush at T+10 of a divide.
    d0 = done_seen;
    step(1'b1, 3'b011, 32'd100, 32'd7);
    #1 chk("flush div stall T", {63'd0, bus.stallE}, 64'd1);
    for (int k = 1; k <= 10; k++) step(1'b0, 3'b000, '0, '0);
    bus.flushE = 1'b1;
    @(posedge clk); #1;
    bus.flushE = 1'b0;
    #1;
    chk("flush stall", {63'd0, bus.stallE}, 64'd0);
    chk("flush done", {63'd0, bus.doneE}, 64'd0);
    chk("flush hilo", bus.hiloE, 64'hAAAAAAAA_55555555);
    bus.startE = 1'b1;
    bus.opE    = 3'b101;
    bus.srcaE  = 32'h0BADF00D;
    #1 chk("mtlo after flush stall", {63'd0, bus.stallE}, 64'd0);
    repeat (40) step(1'b0, 3'b000, '0, '0);
    #1;
    chk("mtlo after flush", bus.hiloE, 64'hAAAAAAAA_0BADF00D);
    chk("flush no done", 64'(done_seen - d0), 64'd0);

    // Reset at T+5 of a divide.
    d0 = done_seen;
    step(1'b1, 3'b010, 32'hFFFFFFF9, 32'd2);
    for (int k = 1; k <= 5; k++) step(1'b0, 3'b000, '0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst mid stall", {63'd0, bus.stallE}, 64'd0);
    chk("rst mid hilo", bus.hiloE, 64'd0);
    chk("rst mid done", {63'd0, bus.doneE}, 64'd0);
    repeat (40) step(1'b0, 3'b000, '0, '0);
    #1;
    chk("rst no done", 64'(done_seen - d0), 64'd0);
    chk("rst hilo stays", bus.hiloE, 64'd0);

    do_md("divu after rst", 3'b011, 32'hFFFFFFFF, 32'd16, 33, 64'h0000000F_0FFFFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
